// File: rtl/pushbutton_step_ctrl_pkg.sv
// pushbutton_pkg
//   Shared types and constants for the front-panel push-button controller.
//   mode_e       : processor clocking mode (STEP / RUN)
//   BTN_STEP     : button channel that issues a single step
//   BTN_MODE     : button channel that toggles STEP <-> RUN
//   DEF_*        : default timing/width values for a 50 MHz system clock
//   cnt_width()  : counter width able to hold 0..n-1 (never below 1 bit)
package pushbutton_pkg;

  typedef enum logic {
    STEP = 1'b0,
    RUN  = 1'b1
  } mode_e;

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;

  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int DEF_PRESCALE        = 50000;   // 1 ms at 50 MHz
  localparam int DEF_RATE_W          = 8;
  localparam int DEF_CNT_W           = 16;

  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pushbutton_step_ctrl_if.sv
// pushbutton_step_ctrl_if
//   Groups the button, configuration and processor-clocking signals.
//   master : board / test side (drives btn_raw, clear, run_rate)
//   slave  : controller side (drives the debounced levels, strobes,
//            cpu_step, run_mode and step_count)
interface pushbutton_step_ctrl_if
  import pushbutton_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN,
  parameter int RATE_W  = DEF_RATE_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic [NUM_BTN-1:0] btn_raw;
  logic               clear;
  logic [RATE_W-1:0]  run_rate;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               cpu_step;
  logic               run_mode;
  logic [CNT_W-1:0]   step_count;

  modport master (
    output btn_raw, clear, run_rate,
    input  btn_level, btn_press, btn_release, cpu_step, run_mode, step_count
  );

  modport slave (
    input  btn_raw, clear, run_rate,
    output btn_level, btn_press, btn_release, cpu_step, run_mode, step_count
  );

endinterface

// File: rtl/pushbutton_step_ctrl_debounce.sv
// debounce_channel
//   One button channel: 2-FF synchroniser, stability counter and
//   registered edge strobes.
//   clk_50MHz   : system clock
//   push_reset  : asynchronous reset, active-low
//   btn_raw     : raw asynchronous button, active-high
//   btn_level   : debounced level
//   btn_press   : one-cycle strobe on a debounced 0->1 change
//   btn_release : one-cycle strobe on a debounced 1->0 change
module debounce_channel
  import pushbutton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_50MHz,
  input  logic push_reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int           W        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic         sync1_q, sync2_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         level_q, level_d;
  logic         press_q, press_d;
  logic         rel_q, rel_d;

  // The counter holds the number of consecutive mismatching cycles already
  // seen; the level flips on the cycle that would make it DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge push_reset) begin
    if (!push_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: rtl/pushbutton_step_ctrl.sv
// pushbutton_step_ctrl
//   Front-panel controller: debounces NUM_BTN buttons and generates the
//   processor clock-enable either one step per press or periodically.
//   clk_50MHz  : system clock
//   push_reset : asynchronous reset, active-low
//   bus        : slave side of pushbutton_step_ctrl_if
//                (btn_raw, clear, run_rate in; btn_level, btn_press,
//                 btn_release, cpu_step, run_mode, step_count out)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   STEP  | cpu_step follows btn_press[BTN_STEP]; run timers held at 0
//   RUN   | cpu_step every max(run_rate,1) run ticks; step button ignored
module pushbutton_step_ctrl
  import pushbutton_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESCALE        = DEF_PRESCALE,
  parameter int RATE_W          = DEF_RATE_W,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                     clk_50MHz,
  input logic                     push_reset,
  pushbutton_step_ctrl_if.slave   bus
);

  localparam int            PW         = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [RATE_W:0]  RATE_ONE = (RATE_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [0:0]    ST_STEP    = 1'(STEP);
  localparam logic [0:0]    ST_RUN     = 1'(RUN);

  logic [NUM_BTN-1:0] level_w, press_w, rel_w;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_50MHz  (clk_50MHz),
      .push_reset (push_reset),
      .btn_raw    (bus.btn_raw[g]),
      .btn_level  (level_w[g]),
      .btn_press  (press_w[g]),
      .btn_release(rel_w[g])
    );
  end

  logic [0:0]        state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              step_q, step_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [RATE_W:0]   eff_rate;
  logic [RATE_W:0]   rate_next;

  always_comb begin
    // run_rate of 0 behaves as 1; one extra bit keeps rate_next from wrapping
    eff_rate  = (bus.run_rate == '0) ? RATE_ONE : {1'b0, bus.run_rate};
    rate_next = {1'b0, rate_q} + RATE_ONE;

    state_d = state_q;
    presc_d = presc_q;
    rate_d  = rate_q;
    step_d  = 1'b0;

    if (state_q == ST_STEP) begin
      step_d  = press_w[BTN_STEP];
      presc_d = '0;
      rate_d  = '0;
      if (press_w[BTN_MODE]) state_d = ST_RUN;
    end else begin
      if (press_w[BTN_MODE]) begin
        // leaving RUN: drop any partial period, never step on this edge
        state_d = ST_STEP;
        presc_d = '0;
        rate_d  = '0;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        // live compare so a lowered run_rate fires on the next tick
        if (rate_next >= eff_rate) begin
          step_d = 1'b1;
          rate_d = '0;
        end else begin
          rate_d = rate_next[RATE_W-1:0];
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end

    // clear wins over a coincident step
    if (bus.clear)   count_d = '0;
    else if (step_d) count_d = count_q + CNT_ONE;
    else             count_d = count_q;
  end

  always_ff @(posedge clk_50MHz or negedge push_reset) begin
    if (!push_reset) begin
      state_q <= ST_STEP;
      presc_q <= '0;
      rate_q  <= '0;
      step_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rate_q  <= rate_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = rel_w;
  assign bus.cpu_step    = step_q;
  assign bus.run_mode    = state_q[0];
  assign bus.step_count  = count_q;

endmodule

// File: tb/tb_pushbutton_step_ctrl.sv
module tb_pushbutton_step_ctrl;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int PS  = 3;
  localparam int RW  = 8;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pushbutton_step_ctrl_if #(.NUM_BTN(NB), .RATE_W(RW), .CNT_W(CW)) bus ();

  pushbutton_step_ctrl #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .PRESCALE(PS), .RATE_W(RW), .CNT_W(CW)
  ) dut (
    .clk_50MHz (clk),
    .push_reset(rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [NB-1:0] hist[$];        // raw sample taken at each edge since reset
  int            last_flip[NB];  // edge number of the last accepted change
  logic [NB-1:0] m_level, m_press, m_rel;
  logic          m_step, m_run;
  int            m_count, elapsed, ticks;

  // observation log
  int cyc_no = 0;
  int step_at[$];
  int p0_at[$];
  int run_at[$];
  int rise2_at[$];
  int p2_n;
  logic prev_mode, prev_lvl2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < NB; c++) last_flip[c] = 0;
    m_level = '0; m_press = '0; m_rel = '0;
    m_step = 1'b0; m_run = 1'b0;
    m_count = 0; elapsed = 0; ticks = 0;
  endtask

  // value seen by the stability logic at edge j: raw from two edges earlier
  function automatic logic delayed(input int j, input int c);
    if (j < 3) return 1'b0;
    return hist[j-3][c];
  endfunction

  task automatic model_edge();
    logic step;
    logic stable;
    logic [NB-1:0] np, nr;
    int eff, k;
    eff  = (bus.run_rate == 0) ? 1 : int'(bus.run_rate);
    step = 1'b0;
    if (!m_run) begin
      step = m_press[0];
      if (m_press[1]) begin
        m_run = 1'b1; elapsed = 0; ticks = 0;
      end
    end else if (m_press[1]) begin
      m_run = 1'b0;
    end else begin
      elapsed++;
      if (elapsed % PS == 0) begin
        ticks++;
        if (ticks >= eff) begin
          step = 1'b1; ticks = 0;
        end
      end
    end
    if (bus.clear) m_count = 0;
    else if (step) m_count = (m_count + 1) % (CMAX + 1);
    m_step = step;

    // a change is accepted once DEB consecutive edges after the last
    // accepted change all saw the opposite value
    hist.push_back(bus.btn_raw);
    k = hist.size();
    np = '0; nr = '0;
    for (int c = 0; c < NB; c++) begin
      stable = (k - DEB + 1 > last_flip[c]);
      for (int j = k - DEB + 1; j <= k; j++)
        if (stable && delayed(j, c) == m_level[c]) stable = 1'b0;
      if (stable) begin
        last_flip[c] = k;
        np[c] = ~m_level[c];
        nr[c] = m_level[c];
        m_level[c] = ~m_level[c];
      end
    end
    m_press = np;
    m_rel   = nr;
  endtask

  task automatic check_all();
    chk("btn_level",   bus.btn_level,   m_level);
    chk("btn_press",   bus.btn_press,   m_press);
    chk("btn_release", bus.btn_release, m_rel);
    chk("cpu_step",    bus.cpu_step,    m_step);
    chk("run_mode",    bus.run_mode,    m_run);
    chk("step_count",  bus.step_count,  m_count);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, bus.btn_level, 0);
    chk({tag, "_press"}, bus.btn_press, 0);
    chk({tag, "_rel"},   bus.btn_release, 0);
    chk({tag, "_step"},  bus.cpu_step, 0);
    chk({tag, "_mode"},  bus.run_mode, 0);
    chk({tag, "_count"}, bus.step_count, 0);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    cyc_no++;
    check_all();
    if (bus.cpu_step) step_at.push_back(cyc_no);
    if (bus.btn_press[0]) p0_at.push_back(cyc_no);
    if (bus.btn_press[2]) p2_n++;
    if (bus.run_mode && !prev_mode) run_at.push_back(cyc_no);
    if (bus.btn_level[2] && !prev_lvl2) rise2_at.push_back(cyc_no);
    prev_mode = bus.run_mode;
    prev_lvl2 = bus.btn_level[2];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tap(input int c);
    bus.btn_raw[c] = 1'b1;
    run(8);
    bus.btn_raw[c] = 1'b0;
    run(8);
  endtask

  initial begin
    int t0;
    bus.btn_raw  = '0;
    bus.clear    = 1'b0;
    bus.run_rate = 8'd2;
    prev_mode = 1'b0; prev_lvl2 = 1'b0; p2_n = 0;
    model_reset();

    #2 rst_n = 1'b0;
    #10;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: debounce-only channel
    t0 = cyc_no;
    bus.btn_raw[2] = 1'b1;
    run(10);
    chk("t1_rise_n", rise2_at.size(), 1);
    if (rise2_at.size() > 0) chk("t1_latency", rise2_at[0] - t0, 6);
    chk("t1_press_n", p2_n, 1);
    chk("t1_no_step", step_at.size(), 0);
    bus.btn_raw[2] = 1'b0;
    run(10);

    // 2: glitch rejection, then a real step press
    p0_at.delete(); step_at.delete();
    bus.btn_raw[0] = 1'b1;
    run(3);
    bus.btn_raw[0] = 1'b0;
    run(8);
    chk("t2_glitch_press", p0_at.size(), 0);
    chk("t2_glitch_level", bus.btn_level[0], 0);
    tap(0);
    chk("t2_press_n", p0_at.size(), 1);
    chk("t2_step_n", step_at.size(), 1);
    if (p0_at.size() == 1 && step_at.size() == 1)
      chk("t2_step_lag", step_at[0] - p0_at[0], 1);
    chk("t2_count", bus.step_count, 1);

    // 3: enter RUN at rate 2, then rate 0
    step_at.delete(); run_at.delete();
    bus.btn_raw[1] = 1'b1;
    run(8);
    bus.btn_raw[1] = 1'b0;
    run(20);
    chk("t3_mode", bus.run_mode, 1);
    chk("t3_entry_n", run_at.size(), 1);
    chk("t3_steps_ge2", step_at.size() >= 2, 1);
    if (run_at.size() == 1 && step_at.size() >= 2) begin
      chk("t3_first", step_at[0] - run_at[0], 6);
      chk("t3_period", step_at[1] - step_at[0], 6);
    end
    bus.run_rate = 8'd0;
    run(4);
    step_at.delete();
    run(12);
    chk("t3_steps_ge3", step_at.size() >= 3, 1);
    for (int i = 1; i < step_at.size(); i++)
      chk("t3_period0", step_at[i] - step_at[i-1], 3);

    // 4: step button ignored in RUN; mode button leaves RUN
    bus.run_rate = 8'd2;
    run(8);
    step_at.delete();
    tap(0);
    run(14);
    chk("t4_steps_ge4", step_at.size() >= 4, 1);
    for (int i = 1; i < step_at.size(); i++)
      chk("t4_period", step_at[i] - step_at[i-1], 6);
    tap(1);
    step_at.delete();
    run(30);
    chk("t4_mode", bus.run_mode, 0);
    chk("t4_no_step", step_at.size(), 0);

    // 5: step_count wrap and clear priority
    bus.run_rate = 8'd0;
    tap(1);
    for (int i = 0; i < 1200 && m_count < CMAX - 15; i++) cyc();
    chk("t5_reach", m_count >= CMAX - 15, 1);
    tap(1);
    chk("t5_mode", bus.run_mode, 0);
    for (int i = 0; i < 20 && m_count != CMAX; i++) tap(0);
    chk("t5_full", bus.step_count, CMAX);
    tap(0);
    chk("t5_wrap", bus.step_count, 0);
    tap(1);
    run(4);
    step_at.delete();
    bus.clear = 1'b1;
    run(4);
    bus.clear = 1'b0;
    chk("t5_clear_step", step_at.size() >= 1, 1);
    chk("t5_clear", bus.step_count, 0);

    // 6: reset mid-RUN with the step button held
    bus.btn_raw[0] = 1'b1;
    run(10);
    #1 rst_n = 1'b0;
    #1;
    check_zero("t6_reset");
    model_reset();
    prev_mode = 1'b0; prev_lvl2 = 1'b0;
    p0_at.delete(); step_at.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = cyc_no;
    chk("t6_mode", bus.run_mode, 0);
    run(10);
    chk("t6_press_n", p0_at.size(), 1);
    if (p0_at.size() == 1) chk("t6_press_lat", p0_at[0] - t0, 6);
    chk("t6_step_n", step_at.size(), 1);
    if (step_at.size() == 1) chk("t6_step_lat", step_at[0] - t0, 7);
    bus.btn_raw[0] = 1'b0;
    run(10);

    // random phase against the reference model
    for (int seg = 0; seg < 200; seg++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 2) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
      bus.run_rate = RW'($urandom_range(0, 3));
      bus.clear = ($urandom_range(0, 15) == 0);
      run(1);
      bus.clear = 1'b0;
      run($urandom_range(1, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
